spi_master: RTL and testbench

// Byte-wide SPI mode-0 master engine and the far end of the load/store unit's SPI CSR interface.
// - Accepts a command byte on spi_trigger and shifts it out MSB-first on MOSI.
// - Captures 8 MISO bits, returns them on spi_response and reports progress on spi_busy.
// - spi_busy drives spi_csr[0].
// - Chip select comes from SPI_CSR bit 2 (software-controlled, active-low on the pin).

---
 rtl/spi_master.sv | 117 +++++++++++
 tb/tb_spi_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master: shifts a command byte out MSB-first on MOSI while
// capturing 8 MISO bits, with a software-driven chip select passed through a register.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_trigger,
  input  logic [7:0] spi_command,
  input  logic       spi_cs_ctrl,
  input  logic       spi_miso,
  output logic       spi_busy,
  output logic [7:0] spi_response,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t           state;
  logic             armed;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  // Bit 7 of the command goes straight onto MOSI at start, so only the
  // remaining seven bits need to be kept for shifting.
  logic [6:0]       tx_sr;
  logic [7:0]       rx_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      armed        <= 1'b0;
      bit_cnt      <= 3'd0;
      div_cnt      <= '0;
      tx_sr        <= 7'd0;
      rx_sr        <= 8'd0;
      spi_busy     <= 1'b0;
      spi_response <= 8'h00;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
      spi_cs_n     <= 1'b1;
    end else begin
      spi_cs_n <= spi_cs_ctrl;

      // A low trigger re-arms; a start consumes the arm, so a held level
      // produces a single transfer.
      if (!spi_trigger) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          spi_sclk <= 1'b0;
          if (spi_trigger && armed) begin
            armed    <= 1'b0;
            tx_sr    <= spi_command[6:0];
            spi_mosi <= spi_command[7];
            spi_busy <= 1'b1;
            bit_cnt  <= 3'd0;
            div_cnt  <= '0;
            state    <= LOW;
          end
        end

        LOW: begin
          if (div_cnt == DIV_TC) begin
            spi_sclk <= 1'b1;
            rx_sr    <= {rx_sr[6:0], spi_miso};
            div_cnt  <= '0;
            state    <= HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        HIGH: begin
          if (div_cnt == DIV_TC) begin
            spi_sclk <= 1'b0;
            div_cnt  <= '0;
            if (bit_cnt == 3'd7) begin
              state <= DONE;
            end else begin
              tx_sr    <= {tx_sr[5:0], 1'b0};
              spi_mosi <= tx_sr[6];
              bit_cnt  <= bit_cnt + 3'd1;
              state    <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DONE: begin
          spi_sclk     <= 1'b0;
          spi_response <= rx_sr;
          spi_busy     <= 1'b0;
          spi_mosi     <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed + randomized bench for spi_master: a slave model feeds MISO per SCLK rise and
// a monitor collects MOSI bits, busy length and edge counts for comparison.
module tb_spi_master;
  localparam int CLK_DIV  = 4;
  localparam int BUSY_LEN = 16 * CLK_DIV + 1;
  localparam int LIMIT    = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_trigger = 1'b0;
  logic [7:0] spi_command = 8'h00;
  logic       spi_cs_ctrl = 1'b1;
  logic       spi_miso;
  logic       spi_busy;
  logic [7:0] spi_response;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;

  logic       loopback = 1'b0;
  logic       slave_bit = 1'b0;
  logic [7:0] slave_byte = 8'h00;

  // Monitor results
  int         rise_cnt = 0;
  int         busy_cycles = 0;
  int         busy_starts = 0;
  logic [7:0] mosi_bits = 8'h00;
  logic       mosi_seen_one = 1'b0;
  logic       sclk_idle_hi = 1'b0;
  logic       sclk_prev = 1'b0;
  logic       busy_prev = 1'b0;

  int tests = 0;
  int fails = 0;

  assign spi_miso = loopback ? spi_mosi : slave_bit;

  spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_trigger (spi_trigger),
    .spi_command (spi_command),
    .spi_cs_ctrl (spi_cs_ctrl),
    .spi_miso    (spi_miso),
    .spi_busy    (spi_busy),
    .spi_response(spi_response),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n)
  );

  always #5 clk = ~clk;

  // Slave and bus monitor: on each SCLK rise record MOSI and present the next slave bit.
  always @(negedge clk) begin
    if (spi_busy && !busy_prev) busy_starts = busy_starts + 1;
    if (spi_busy) busy_cycles = busy_cycles + 1;
    if (spi_busy && spi_mosi) mosi_seen_one = 1'b1;
    if (spi_sclk && !spi_busy) sclk_idle_hi = 1'b1;
    if (spi_sclk && !sclk_prev) begin
      mosi_bits = {mosi_bits[6:0], spi_mosi};
      rise_cnt  = rise_cnt + 1;
      if (rise_cnt < 8) slave_bit = slave_byte[7 - rise_cnt];
    end
    sclk_prev = spi_sclk;
    busy_prev = spi_busy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_met(input int what);
    case (what)
      0:       return spi_busy === 1'b1;
      1:       return spi_busy === 1'b0;
      default: return (rise_cnt >= 4) && (spi_sclk === 1'b1);
    endcase
  endfunction

  task automatic wait_for(input string tag, input int what);
    int n;
    n = 0;
    while (!cond_met(what) && n < LIMIT) begin
      tick();
      n++;
    end
    tests++;
    assert (n < LIMIT)
    else begin
      fails++;
      $error("FAIL %s: observed timeout after %0d cycles expected event", tag, n);
    end
  endtask

  // One complete transfer; expectations come from the command byte and the slave byte.
  task automatic xfer(input logic [7:0] cmd, input logic [7:0] sbyte, input logic loop,
                      input string tag);
    logic [7:0] resp_before;
    int         s0;
    spi_command = cmd;
    slave_byte  = sbyte;
    slave_bit   = sbyte[7];
    loopback    = loop;
    spi_trigger = 1'b0;
    tick();
    rise_cnt      = 0;
    busy_cycles   = 0;
    mosi_bits     = 8'h00;
    mosi_seen_one = 1'b0;
    s0            = busy_starts;
    resp_before   = spi_response;
    spi_trigger   = 1'b1;
    wait_for({tag, "_start"}, 0);
    check({tag, "_resp_held"}, 32'(spi_response), 32'(resp_before));
    spi_trigger = 1'b0;
    wait_for({tag, "_end"}, 1);
    repeat (3) tick();
    check({tag, "_busy_len"}, 32'(busy_cycles), 32'(BUSY_LEN));
    check({tag, "_rises"}, 32'(rise_cnt), 32'd8);
    check({tag, "_mosi"}, 32'(mosi_bits), 32'(cmd));
    check({tag, "_resp"}, 32'(spi_response), 32'(loop ? cmd : sbyte));
    check({tag, "_starts"}, 32'(busy_starts - s0), 32'd1);
  endtask

  initial begin
    int s0;

    // Reset values, with CS control low to show reset wins
    spi_cs_ctrl = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(spi_busy), 32'd0);
    check("rst_resp", 32'(spi_response), 32'h00);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    rst = 1'b0;
    tick();
    check("cs_fall", 32'(spi_cs_n), 32'd0);
    spi_cs_ctrl = 1'b1;
    #1;
    check("cs_rise_not_yet", 32'(spi_cs_n), 32'd0);
    tick();
    check("cs_rise", 32'(spi_cs_n), 32'd1);

    // Loopback A5, then MISO=1 with command 00
    xfer(8'hA5, 8'h00, 1'b1, "loop_a5");
    xfer(8'h00, 8'hFF, 1'b0, "miso_ones");
    check("zero_cmd_mosi_low", 32'(mosi_seen_one), 32'd0);

    // Randomized transfers
    for (int i = 0; i < 6; i++) begin
      xfer(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    // Trigger held high: exactly one transfer, then a new one only after low-high
    spi_trigger = 1'b0;
    tick();
    s0 = busy_starts;
    spi_trigger = 1'b1;
    repeat (200) tick();
    check("held_one_xfer", 32'(busy_starts - s0), 32'd1);
    check("held_idle", 32'(spi_busy), 32'd0);
    spi_trigger = 1'b0;
    tick();
    spi_trigger = 1'b1;
    repeat (2) tick();
    check("rearm_second", 32'(busy_starts - s0), 32'd2);
    spi_trigger = 1'b0;
    wait_for("rearm_end", 1);

    // Command change and trigger pulse mid-transfer must not disturb the shift
    spi_command = 8'hC3;
    loopback    = 1'b1;
    tick();
    rise_cnt  = 0;
    mosi_bits = 8'h00;
    s0        = busy_starts;
    spi_trigger = 1'b1;
    wait_for("chg_start", 0);
    spi_trigger = 1'b0;
    repeat (10) tick();
    spi_command = 8'h3C;
    spi_trigger = 1'b1;
    tick();
    spi_trigger = 1'b0;
    wait_for("chg_end", 1);
    repeat (20) tick();
    check("chg_mosi", 32'(mosi_bits), 32'hC3);
    check("chg_resp", 32'(spi_response), 32'hC3);
    check("chg_starts", 32'(busy_starts - s0), 32'd1);

    // Asynchronous reset during the high phase of bit 3
    spi_command = 8'h5A;
    loopback    = 1'b0;
    slave_byte  = 8'h96;
    slave_bit   = 1'b1;
    tick();
    rise_cnt    = 0;
    spi_trigger = 1'b1;
    wait_for("mid_rst_reach", 2);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_sclk", 32'(spi_sclk), 32'd0);
    check("mid_rst_busy", 32'(spi_busy), 32'd0);
    check("mid_rst_resp", 32'(spi_response), 32'h00);
    tick();
    rst = 1'b0;
    s0 = busy_starts;
    repeat (100) tick();
    check("no_resume_starts", 32'(busy_starts - s0), 32'd0);
    check("no_resume_busy", 32'(spi_busy), 32'd0);
    spi_trigger = 1'b0;

    // Recovery after reset
    xfer(8'h69, 8'h1E, 1'b0, "post_rst");

    check("sclk_idle_low", 32'(sclk_idle_hi), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
